// File: rtl/bc_polinomio.sv
// ---------------------------------------------------------------------------
// bc_polinomio
// Control block for the polynomial datapath. Sequences a Horner evaluation
// y = ((A*x) + B)*x + C by driving the datapath muxes, register loads and
// the ULA add/multiply select, with a start/done handshake on the outside.
//
// Parameters:
//   OP_LAT      cycles each arithmetic state is held (1..15)
//
// Ports:
//   clk         system clock, rising edge
//   RST         asynchronous active-low reset
//   start       launch a new evaluation (sampled only in IDLE)
//   abort       synchronous cancel back to IDLE
//   M0          coefficient mux   00 zero, 01 A, 10 B, 11 C
//   M1          ULA operand-1 mux 00 M0 out, 01 R0, 10 R1, 11 R2
//   M2          ULA operand-2 mux 00 R0, 01 M0 out, 10 R1, 11 R2
//   LX          load x into R0
//   LH          load ULA result into R1
//   LS          load ULA result into R2
//   H           ULA op select, 0 add, 1 multiply
//   busy        high in every state except IDLE
//   done        one-cycle pulse when R2 holds the result
//   eval_count  (only with BC_EVAL_COUNT_EN) 8-bit count of done pulses
//
// Optional feature macro: BC_EVAL_COUNT_EN
// ---------------------------------------------------------------------------
module bc_polinomio #(
  parameter int OP_LAT = 1
) (
  input  logic       clk,
  input  logic       RST,
  input  logic       start,
  input  logic       abort,
  output logic [1:0] M0,
  output logic [1:0] M1,
  output logic [1:0] M2,
  output logic       LX,
  output logic       LH,
  output logic       LS,
  output logic       H,
  output logic       busy,
  output logic       done
`ifdef BC_EVAL_COUNT_EN
  ,
  output logic [7:0] eval_count
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOADX,
    S_AX,
    S_ADDB,
    S_MULX,
    S_ADDC,
    S_DONE
  } state_t;

  typedef struct packed {
    logic [1:0] m0;
    logic [1:0] m1;
    logic [1:0] m2;
    logic       lx;
    logic       lh;
    logic       ls;
    logic       h;
    logic       busy;
    logic       done;
  } ctrl_t;

  localparam logic [3:0] LAST_CNT = 4'(OP_LAT - 1);

  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  ctrl_t ctrl_q, ctrl_d;
  logic last_q;
  logic last_d;

  assign last_q = (cnt_q == LAST_CNT);

  // Next-state and latency counter. The counter is zeroed whenever a state
  // is left so every arithmetic state starts counting from 0.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (abort) begin
      state_d = S_IDLE;
      cnt_d   = 4'd0;
    end else begin
      unique case (state_q)
        S_IDLE:  if (start) state_d = S_LOADX;
        S_LOADX: begin
          state_d = S_AX;
          cnt_d   = 4'd0;
        end
        S_AX, S_ADDB, S_MULX, S_ADDC: begin
          if (last_q) begin
            cnt_d = 4'd0;
            unique case (state_q)
              S_AX:    state_d = S_ADDB;
              S_ADDB:  state_d = S_MULX;
              S_MULX:  state_d = S_ADDC;
              default: state_d = S_DONE;
            endcase
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: begin
          state_d = S_IDLE;
          cnt_d   = 4'd0;
        end
      endcase
    end
  end

  // Control word is decoded from the upcoming state/counter and then
  // registered, so outputs come straight from flops and line up with the
  // state they belong to. Load strobes fire only in the last cycle.
  assign last_d = (cnt_d == LAST_CNT);

  always_comb begin
    ctrl_d      = '0;
    ctrl_d.busy = (state_d != S_IDLE);
    unique case (state_d)
      S_LOADX: ctrl_d.lx = 1'b1;
      S_AX: begin
        ctrl_d.m0 = 2'b01;
        ctrl_d.h  = 1'b1;
        ctrl_d.lh = last_d;
      end
      S_ADDB: begin
        ctrl_d.m0 = 2'b10;
        ctrl_d.m1 = 2'b10;
        ctrl_d.m2 = 2'b01;
        ctrl_d.lh = last_d;
      end
      S_MULX: begin
        ctrl_d.m1 = 2'b10;
        ctrl_d.h  = 1'b1;
        ctrl_d.lh = last_d;
      end
      S_ADDC: begin
        ctrl_d.m0 = 2'b11;
        ctrl_d.m1 = 2'b10;
        ctrl_d.m2 = 2'b01;
        ctrl_d.ls = last_d;
      end
      S_DONE:  ctrl_d.done = 1'b1;
      default: ctrl_d = '0;
    endcase
  end

  // State, counter and registered control word.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign M0   = ctrl_q.m0;
  assign M1   = ctrl_q.m1;
  assign M2   = ctrl_q.m2;
  assign LX   = ctrl_q.lx;
  assign LH   = ctrl_q.lh;
  assign LS   = ctrl_q.ls;
  assign H    = ctrl_q.h;
  assign busy = ctrl_q.busy;
  assign done = ctrl_q.done;

`ifdef BC_EVAL_COUNT_EN
  logic [7:0] eval_cnt_q;

  // Counts completed evaluations; wraps naturally at 8 bits and survives
  // abort, only RST clears it.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      eval_cnt_q <= 8'd0;
    end else if (ctrl_q.done) begin
      eval_cnt_q <= eval_cnt_q + 8'd1;
    end
  end

  assign eval_count = eval_cnt_q;
`endif

endmodule

// File: tb/tb_bc_polinomio.sv
// ---------------------------------------------------------------------------
// tb_bc_polinomio
// Directed bench for bc_polinomio. Two controllers are instantiated, one with
// OP_LAT=1 driving a small model of the polynomial datapath, one with
// OP_LAT=3 for the stretched timing. Control outputs are packed into a
// 12-bit word {M0,M1,M2,LX,LH,LS,H,busy,done} and compared to hand-derived
// per-cycle values.
// ---------------------------------------------------------------------------
module tb_bc_polinomio;

  logic clk;
  logic rstN;
  logic start1, abort1, start3, abort3;

  logic [1:0] m0a, m1a, m2a, m0b, m1b, m2b;
  logic lxA, lhA, lsA, hA, busyA, doneA;
  logic lxB, lhB, lsB, hB, busyB, doneB;
`ifdef BC_EVAL_COUNT_EN
  logic [7:0] evalCountA, evalCountB;
`endif

  int checks = 0;
  int errors = 0;

  bc_polinomio #(.OP_LAT(1)) dut1 (
    .clk(clk), .RST(rstN), .start(start1), .abort(abort1),
    .M0(m0a), .M1(m1a), .M2(m2a), .LX(lxA), .LH(lhA), .LS(lsA), .H(hA),
    .busy(busyA), .done(doneA)
`ifdef BC_EVAL_COUNT_EN
    , .eval_count(evalCountA)
`endif
  );

  bc_polinomio #(.OP_LAT(3)) dut3 (
    .clk(clk), .RST(rstN), .start(start3), .abort(abort3),
    .M0(m0b), .M1(m1b), .M2(m2b), .LX(lxB), .LH(lhB), .LS(lsB), .H(hB),
    .busy(busyB), .done(doneB)
`ifdef BC_EVAL_COUNT_EN
    , .eval_count(evalCountB)
`endif
  );

  logic [11:0] word1, word3;
  assign word1 = {m0a, m1a, m2a, lxA, lhA, lsA, hA, busyA, doneA};
  assign word3 = {m0b, m1b, m2b, lxB, lhB, lsB, hB, busyB, doneB};

  // Datapath model hanging off the OP_LAT=1 controller.
  logic [15:0] coefA, coefB, coefC, xIn;
  logic [15:0] r0, r1, r2;
  logic [15:0] m0Out, op1, op2, ulaOut;

  always_comb begin
    m0Out = 16'd0;
    case (m0a)
      2'b01:   m0Out = coefA;
      2'b10:   m0Out = coefB;
      2'b11:   m0Out = coefC;
      default: m0Out = 16'd0;
    endcase
    op1 = m0Out;
    case (m1a)
      2'b01:   op1 = r0;
      2'b10:   op1 = r1;
      2'b11:   op1 = r2;
      default: op1 = m0Out;
    endcase
    op2 = r0;
    case (m2a)
      2'b01:   op2 = m0Out;
      2'b10:   op2 = r1;
      2'b11:   op2 = r2;
      default: op2 = r0;
    endcase
    ulaOut = hA ? 16'(op1 * op2) : 16'(op1 + op2);
  end

  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r0 <= 16'd0;
      r1 <= 16'd0;
      r2 <= 16'd0;
    end else begin
      if (lxA) r0 <= xIn;
      if (lhA) r1 <= ulaOut;
      if (lsA) r2 <= ulaOut;
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected control word, OP_LAT=1, cycle numbers counted from the start pulse.
  function automatic logic [11:0] expLat1(input int cy);
    case (cy)
      1:       return 12'h022;
      2:       return 12'h416;
      3:       return 12'hA52;
      4:       return 12'h216;
      5:       return 12'hE4A;
      6:       return 12'h003;
      default: return 12'h000;
    endcase
  endfunction

  // Expected control word, OP_LAT=3.
  function automatic logic [11:0] expLat3(input int cy);
    case (cy)
      1:          return 12'h022;
      2, 3:       return 12'h406;
      4:          return 12'h416;
      5, 6:       return 12'hA42;
      7:          return 12'hA52;
      8, 9:       return 12'h206;
      10:         return 12'h216;
      11, 12:     return 12'hE42;
      13:         return 12'hE4A;
      14:         return 12'h003;
      default:    return 12'h000;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // One full evaluation on the OP_LAT=1 controller, starting in IDLE.
  task automatic applyStimulus(input string tag, input logic [15:0] a,
                               input logic [15:0] b, input logic [15:0] c,
                               input logic [15:0] x, input logic [15:0] expR2);
    coefA  = a;
    coefB  = b;
    coefC  = c;
    xIn    = x;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int cy = 1; cy <= 7; cy++) begin
      checkOutput($sformatf("%s_c%0d", tag, cy), 32'(word1), 32'(expLat1(cy)));
      if (cy == 6) checkOutput({tag, "_r2"}, 32'(r2), 32'(expR2));
      if (cy < 7) tick();
    end
  endtask

  logic [31:0] doneMask, busyMask;

  initial begin
    rstN   = 1'b0;
    start1 = 1'b0;
    abort1 = 1'b0;
    start3 = 1'b0;
    abort3 = 1'b0;
    coefA  = 16'd0;
    coefB  = 16'd0;
    coefC  = 16'd0;
    xIn    = 16'd0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_word1", 32'(word1), 32'h0);
    checkOutput("reset_word3", 32'(word3), 32'h0);
`ifdef BC_EVAL_COUNT_EN
    checkOutput("reset_evalcnt", 32'(evalCountA), 32'h0);
`endif
    rstN = 1'b1;
    tick();
    checkOutput("idle_after_reset", 32'(word1), 32'h0);

    // Basic sequence plus datapath result 2,3,4 at x=5.
    applyStimulus("basic", 16'd2, 16'd3, 16'd4, 16'd5, 16'd69);

    // Stretched latency on the OP_LAT=3 instance.
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    for (int cy = 1; cy <= 15; cy++) begin
      checkOutput($sformatf("lat3_c%0d", cy), 32'(word3), 32'(expLat3(cy)));
      if (cy < 15) tick();
    end

    // Abort during ADDB, then no strobes or done, then a clean run.
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    tick();
    tick();
    checkOutput("abort_in_addb", 32'(word1), 32'hA52);
    abort1 = 1'b1;
    tick();
    abort1 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("abort_idle_%0d", k), 32'(word1), 32'h0);
      tick();
    end
    applyStimulus("after_abort", 16'd2, 16'd3, 16'd4, 16'd5, 16'd69);

    // abort wins over start in IDLE.
    start1 = 1'b1;
    abort1 = 1'b1;
    tick();
    start1 = 1'b0;
    abort1 = 1'b0;
    checkOutput("abort_prio", 32'(word1), 32'h0);
    tick();
    checkOutput("abort_prio_hold", 32'(word1), 32'h0);

    // Back-to-back with start held high; reset first so the counter starts at 0.
    rstN = 1'b0;
    #2;
    rstN = 1'b1;
    tick();
    doneMask = 32'd0;
    busyMask = 32'd0;
    start1 = 1'b1;
    for (int cy = 1; cy <= 21; cy++) begin
      tick();
      doneMask[cy] = doneA;
      busyMask[cy] = busyA;
    end
    start1 = 1'b0;
    checkOutput("b2b_done_mask", doneMask, 32'h0010_2040);
    checkOutput("b2b_busy_mask", busyMask, 32'h001F_BF7E);
`ifdef BC_EVAL_COUNT_EN
    checkOutput("b2b_evalcnt", 32'(evalCountA), 32'd3);
`endif
    tick();
    checkOutput("b2b_stop", 32'(word1), 32'h0);

    // Asynchronous reset while in MULX.
    coefA  = 16'd2;
    coefB  = 16'd3;
    coefC  = 16'd4;
    xIn    = 16'd5;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    tick();
    tick();
    tick();
    checkOutput("pre_reset_mulx", 32'(word1), 32'h216);
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("async_reset_word", 32'(word1), 32'h0);
`ifdef BC_EVAL_COUNT_EN
    checkOutput("async_reset_evalcnt", 32'(evalCountA), 32'h0);
`endif
    rstN = 1'b1;
    tick();
    checkOutput("post_reset_idle", 32'(word1), 32'h0);

    // 16-bit wrap through the datapath.
    applyStimulus("wrap", 16'd256, 16'd0, 16'd0, 16'd256, 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
